quantum_timer: RTL and testbench

Preemption time-slice timer for the single-cycle MIPS multitasking support. It counts a programmable quantum while a user process runs and raises the one-cycle `timerInt` request consumed by the interruption controller. After firing, it waits for the controller to hand the CPU back to the kernel region before re-arming. It sits beside the interruption controller, fed by the controller's `region` output and the same `changeContext` strobe.

---
 rtl/quantum_timer_pkg.sv | 23 ++
 rtl/quantum_timer_if.sv | 44 ++++
 rtl/quantum_timer_counter.sv | 33 +++
 rtl/quantum_timer.sv | 117 +++++++++++
 tb/tb_quantum_timer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quantum_timer_pkg.sv
// Shared types and default constants for the preemption time-slice timer.
package quantum_timer_pkg;

    localparam int QT_QUANTUM_WIDTH   = 16;
    localparam int QT_DEFAULT_QUANTUM = 100;
    localparam int QT_PCOUNT_WIDTH    = 8;

    // Timer FSM states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COUNT       = 2'd1,
        FIRE        = 2'd2,
        WAIT_KERNEL = 2'd3
    } qt_state_e;

    // A slice may only start for a user process with a non-zero quantum
    function automatic logic slice_can_start(input logic enable,
                                             input logic region,
                                             input logic quantum_nonzero);
        return enable && region && quantum_nonzero;
    endfunction

endpackage

// File: rtl/quantum_timer_if.sv
// Bundle of OS/controller-facing signals of the quantum timer.
// master = OS / interruption controller side, slave = timer side.
interface quantum_timer_if
    import quantum_timer_pkg::*;
#(
    parameter int QUANTUM_WIDTH = QT_QUANTUM_WIDTH,
    parameter int PCOUNT_WIDTH  = QT_PCOUNT_WIDTH
);

    logic                     enable;
    logic                     region;
    logic                     changeContext;
    logic                     loadQuantum;
    logic [QUANTUM_WIDTH-1:0] quantumIn;
    logic                     timerInt;
    logic [QUANTUM_WIDTH-1:0] count;
    logic [PCOUNT_WIDTH-1:0]  preemptCount;
    logic                     busy;

    modport master (
        output enable,
        output region,
        output changeContext,
        output loadQuantum,
        output quantumIn,
        input  timerInt,
        input  count,
        input  preemptCount,
        input  busy
    );

    modport slave (
        input  enable,
        input  region,
        input  changeContext,
        input  loadQuantum,
        input  quantumIn,
        output timerInt,
        output count,
        output preemptCount,
        output busy
    );

endinterface

// File: rtl/quantum_timer_counter.sv
// Loadable down-counter for the remaining slice length.
// Priority: clear > load > dec. Decrement stops at zero so it never wraps.
module quantum_counter
    import quantum_timer_pkg::*;
#(
    parameter int WIDTH = QT_QUANTUM_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);

    // Remaining-cycle register with saturating decrement
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/quantum_timer.sv
// Preemption time-slice timer: counts a programmable quantum while a user
// process runs and raises a one-cycle timerInt, then waits for the
// interruption controller to return to the kernel region before re-arming.
module quantum_timer
    import quantum_timer_pkg::*;
#(
    parameter int QUANTUM_WIDTH   = QT_QUANTUM_WIDTH,
    parameter int DEFAULT_QUANTUM = QT_DEFAULT_QUANTUM,
    parameter int PCOUNT_WIDTH    = QT_PCOUNT_WIDTH
) (
    input logic            clock,
    input logic            reset_n,
    quantum_timer_if.slave bus
);

    qt_state_e                state;
    qt_state_e                next_state;
    logic [QUANTUM_WIDTH-1:0] quantum;
    logic [PCOUNT_WIDTH-1:0]  preempt_cnt;
    logic                     timer_int_q;
    logic                     busy_q;

    logic                     cnt_load;
    logic                     cnt_dec;
    logic                     cnt_clear;
    logic [QUANTUM_WIDTH-1:0] cnt_count;
    logic                     cnt_is_one;

    // Slice counter; the reload value is the quantum register as it was
    // before any same-edge write, so a new quantum only affects later reloads.
    quantum_counter #(
        .WIDTH (QUANTUM_WIDTH)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load),
        .value   (quantum),
        .dec     (cnt_dec),
        .clear   (cnt_clear),
        .count   (cnt_count),
        .is_one  (cnt_is_one)
    );

    // Quantum register, written by the OS
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quantum <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
        end else if (bus.loadQuantum) begin
            quantum <= bus.quantumIn;
        end
    end

    // Next-state decode and counter strobes; in COUNT the kernel/disable
    // exits win over a context switch, which wins over expiry.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (slice_can_start(bus.enable, bus.region, quantum != '0)) begin
                    next_state = COUNT;
                    cnt_load   = 1'b1;
                end
            end
            COUNT: begin
                if (!bus.enable || !bus.region) begin
                    next_state = IDLE;
                    cnt_clear  = 1'b1;
                end else if (bus.changeContext) begin
                    cnt_load   = 1'b1;
                end else if (cnt_is_one) begin
                    next_state = FIRE;
                    cnt_clear  = 1'b1;
                end else begin
                    cnt_dec    = 1'b1;
                end
            end
            FIRE: begin
                next_state = bus.enable ? WAIT_KERNEL : IDLE;
            end
            WAIT_KERNEL: begin
                // No re-fire here: only a kernel return or disable re-arms
                if (!bus.region || !bus.enable) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM state with registered Moore outputs and the expiry counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            timer_int_q <= 1'b0;
            busy_q      <= 1'b0;
            preempt_cnt <= '0;
        end else begin
            state       <= next_state;
            timer_int_q <= (next_state == FIRE);
            busy_q      <= (next_state != IDLE);
            if (state == FIRE) begin
                preempt_cnt <= preempt_cnt + PCOUNT_WIDTH'(1);
            end
        end
    end

    assign bus.timerInt     = timer_int_q;
    assign bus.count        = cnt_count;
    assign bus.preemptCount = preempt_cnt;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_quantum_timer.sv
// Directed testbench for quantum_timer.
module tb_quantum_timer;
    import quantum_timer_pkg::*;

    logic clock;
    logic reset_n;

    quantum_timer_if #(.QUANTUM_WIDTH(16), .PCOUNT_WIDTH(8)) bus ();

    quantum_timer #(
        .QUANTUM_WIDTH   (16),
        .DEFAULT_QUANTUM (100),
        .PCOUNT_WIDTH    (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total;
    int bad;
    int n;
    int gap;
    int pulses;
    int idle_seen;
    int fires;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Tick until timerInt is seen; returns edges taken (limit+1 on timeout)
    task automatic wait_pulse(input int limit, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!bus.timerInt && edges <= limit);
    endtask

    task automatic load_q(input logic [15:0] q);
        bus.loadQuantum = 1'b1;
        bus.quantumIn   = q;
        tick();
        bus.loadQuantum = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.enable        = 1'b0;
        bus.region        = 1'b0;
        bus.changeContext = 1'b0;
        bus.loadQuantum   = 1'b0;
        bus.quantumIn     = '0;
        reset_n           = 1'b0;
        #1;
        chk("rst_timerInt", 32'(bus.timerInt), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_pcount", 32'(bus.preemptCount), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Default quantum of 100
        bus.enable = 1'b1;
        bus.region = 1'b1;
        tick();
        chk("t1_entry_count", 32'(bus.count), 100);
        chk("t1_entry_busy", 32'(bus.busy), 1);
        wait_pulse(200, n);
        chk("t1_latency", 32'(n), 100);
        chk("t1_fire_count", 32'(bus.count), 0);
        tick();
        chk("t1_pulse_width", 32'(bus.timerInt), 0);
        chk("t1_pcount", 32'(bus.preemptCount), 1);
        chk("t1_wait_busy", 32'(bus.busy), 1);
        bus.region = 1'b0;
        tick();
        chk("t1_idle_busy", 32'(bus.busy), 0);

        // Quantum 5 and back-to-back slices
        load_q(16'd5);
        bus.region = 1'b1;
        tick();
        chk("t2_entry_count", 32'(bus.count), 5);
        wait_pulse(20, n);
        chk("t2_latency", 32'(n), 5);
        gap = 0;
        bus.region = 1'b0;
        tick(); gap++;
        tick(); gap++;
        chk("t2_idle_busy", 32'(bus.busy), 0);
        bus.region = 1'b1;
        tick(); gap++;
        chk("t2_reentry_count", 32'(bus.count), 5);
        wait_pulse(20, n);
        gap += n;
        chk("t2_gap", 32'(gap), 8);
        tick();
        bus.region = 1'b0;
        tick();
        chk("t2_pcount", 32'(bus.preemptCount), 3);

        // Quantum 10, context switch at count 3
        load_q(16'd10);
        bus.region = 1'b1;
        tick();
        chk("t3_entry_count", 32'(bus.count), 10);
        for (int i = 0; i < 7; i++) tick();
        chk("t3_count3", 32'(bus.count), 3);
        bus.changeContext = 1'b1;
        tick();
        bus.changeContext = 1'b0;
        chk("t3_reload", 32'(bus.count), 10);
        wait_pulse(30, n);
        chk("t3_latency", 32'(n), 10);
        tick();
        chk("t3_pcount", 32'(bus.preemptCount), 4);

        // Held in WAIT_KERNEL while region stays user
        pulses    = 0;
        idle_seen = 0;
        for (int i = 0; i < 50; i++) begin
            bus.changeContext = (i == 10);
            tick();
            if (bus.timerInt) pulses++;
            if (!bus.busy) idle_seen++;
        end
        bus.changeContext = 1'b0;
        chk("t4_no_refire", 32'(pulses), 0);
        chk("t4_busy_held", 32'(idle_seen), 0);
        bus.region = 1'b0;
        tick();
        chk("t4_idle_busy", 32'(bus.busy), 0);

        // Quantum 0 disables preemption
        load_q(16'd0);
        bus.region = 1'b1;
        pulses    = 0;
        idle_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.timerInt) pulses++;
            if (bus.busy) idle_seen++;
        end
        chk("t5_q0_pulses", 32'(pulses), 0);
        chk("t5_q0_busy", 32'(idle_seen), 0);

        // Same-edge quantum write and context switch
        bus.region = 1'b0;
        load_q(16'd4);
        bus.region = 1'b1;
        tick();
        chk("t5_entry_count", 32'(bus.count), 4);
        tick();
        bus.loadQuantum   = 1'b1;
        bus.quantumIn     = 16'd7;
        bus.changeContext = 1'b1;
        tick();
        bus.loadQuantum   = 1'b0;
        bus.changeContext = 1'b0;
        chk("t5_old_q_reload", 32'(bus.count), 4);
        wait_pulse(20, n);
        chk("t5_latency", 32'(n), 4);
        tick();
        bus.region = 1'b0;
        tick();
        bus.region = 1'b1;
        tick();
        chk("t5_new_q", 32'(bus.count), 7);
        chk("t5_pcount", 32'(bus.preemptCount), 5);

        // Asynchronous reset mid-slice
        for (int i = 0; i < 5; i++) tick();
        chk("t6_count2", 32'(bus.count), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_count", 32'(bus.count), 0);
        chk("t6_async_busy", 32'(bus.busy), 0);
        chk("t6_async_int", 32'(bus.timerInt), 0);
        chk("t6_async_pcount", 32'(bus.preemptCount), 0);
        #3;
        reset_n = 1'b1;
        tick();
        chk("t6_default_q", 32'(bus.count), 100);
        pulses = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus.timerInt) pulses++;
        end
        chk("t6_no_early_pulse", 32'(pulses), 0);
        tick();
        chk("t6_full_slice", 32'(bus.timerInt), 1);
        tick();
        bus.region = 1'b0;
        tick();

        // preemptCount wrap
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        load_q(16'd1);
        fires = 0;
        for (int i = 0; i < 255; i++) begin
            bus.region = 1'b1;
            tick();
            tick();
            if (bus.timerInt) fires++;
            bus.region = 1'b0;
            tick();
            tick();
        end
        chk("t7_fires", 32'(fires), 255);
        chk("t7_pcount255", 32'(bus.preemptCount), 255);
        bus.region = 1'b1;
        tick();
        tick();
        bus.region = 1'b0;
        tick();
        chk("t7_wrap", 32'(bus.preemptCount), 0);
        tick();

        // Disable during FIRE still counts the expiry
        bus.region = 1'b1;
        tick();
        tick();
        chk("t8_fire", 32'(bus.timerInt), 1);
        bus.enable = 1'b0;
        tick();
        chk("t8_idle_busy", 32'(bus.busy), 0);
        chk("t8_pcount", 32'(bus.preemptCount), 1);

        // Kernel entry and disable during COUNT
        bus.enable = 1'b1;
        bus.region = 1'b0;
        load_q(16'd6);
        bus.region = 1'b1;
        tick();
        tick();
        chk("t9_count5", 32'(bus.count), 5);
        bus.region = 1'b0;
        tick();
        chk("t9_syscall_count", 32'(bus.count), 0);
        chk("t9_syscall_busy", 32'(bus.busy), 0);
        bus.region = 1'b1;
        tick();
        chk("t9_reentry", 32'(bus.count), 6);
        bus.enable = 1'b0;
        tick();
        chk("t9_disable_count", 32'(bus.count), 0);
        chk("t9_disable_busy", 32'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
